// File: rtl/clk_duty_monitor.sv
// clk_duty_monitor: receive-side checker for a divided clock.
// Measures the period and high time of sig_in in src_clk cycles, once per
// sig_in cycle, and compares each measurement against the expected values.
// Reports per-measurement mismatch, a lock level after LOCK_COUNT consecutive
// matches, and a stuck level when no rising edge arrives for TIMEOUT cycles.
module clk_duty_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 5,
  parameter int EXP_HIGH   = 1,
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 32
) (
  input  logic             src_clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             mismatch,
  output logic             locked,
  output logic             stuck
);

  localparam int MC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    STUCK   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             sig_d;
  logic [CNT_W-1:0] period_cnt, period_cnt_n;
  logic [CNT_W-1:0] high_cnt, high_cnt_n;
  logic [MC_W-1:0]  match_cnt, match_cnt_n;
  logic [CNT_W-1:0] period_n, high_time_n;
  logic             meas_valid_n, mismatch_n, locked_n, stuck_n;

  logic             rise;
  logic             meas_bad;
  logic [CNT_W-1:0] period_inc, high_inc;
  logic [MC_W-1:0]  match_inc;

  // Edge detect and saturating counter increments shared by all states.
  always_comb begin
    rise       = sig_in & ~sig_d;
    meas_bad   = (period_cnt != CNT_W'(EXP_PERIOD)) || (high_cnt != CNT_W'(EXP_HIGH));
    period_inc = (&period_cnt) ? period_cnt : period_cnt + CNT_W'(1);
    high_inc   = (sig_in && !(&high_cnt)) ? high_cnt + CNT_W'(1) : high_cnt;
    match_inc  = match_cnt + MC_W'(1);
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold its value.
    state_n      = state;
    period_cnt_n = period_cnt;
    high_cnt_n   = high_cnt;
    match_cnt_n  = match_cnt;
    period_n     = period;
    high_time_n  = high_time;
    meas_valid_n = 1'b0;
    mismatch_n   = 1'b0;
    locked_n     = locked;
    stuck_n      = stuck;

    case (state)
      // First edge only starts counting: the cycle before it was incomplete.
      IDLE, STUCK: begin
        if (rise) begin
          period_cnt_n = CNT_W'(1);
          high_cnt_n   = CNT_W'(1);
          stuck_n      = 1'b0;
          state_n      = ACQUIRE;
        end
      end

      ACQUIRE, LOCKED: begin
        if (rise) begin
          period_cnt_n = CNT_W'(1);
          high_cnt_n   = CNT_W'(1);
          period_n     = period_cnt;
          high_time_n  = high_cnt;
          meas_valid_n = 1'b1;
          mismatch_n   = meas_bad;
          if (meas_bad) begin
            match_cnt_n = '0;
            locked_n    = 1'b0;
            state_n     = ACQUIRE;
          end else if (state == ACQUIRE) begin
            match_cnt_n = match_inc;
            if (match_inc == MC_W'(LOCK_COUNT)) begin
              locked_n = 1'b1;
              state_n  = LOCKED;
            end
          end
        end else begin
          period_cnt_n = period_inc;
          high_cnt_n   = high_inc;
          if (period_cnt == CNT_W'(TIMEOUT - 1)) begin
            stuck_n     = 1'b1;
            locked_n    = 1'b0;
            match_cnt_n = '0;
            state_n     = STUCK;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State, counters and outputs, cleared by synchronous reset.
  always_ff @(posedge src_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state      <= IDLE;
      sig_d      <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      state      <= state_n;
      sig_d      <= sig_in;
      period_cnt <= period_cnt_n;
      high_cnt   <= high_cnt_n;
      match_cnt  <= match_cnt_n;
      period     <= period_n;
      high_time  <= high_time_n;
      meas_valid <= meas_valid_n;
      mismatch   <= mismatch_n;
      locked     <= locked_n;
      stuck      <= stuck_n;
    end
  end

endmodule
